// File: rtl/switch_mcu_pkg.sv
// rtl/switch_mcu_pkg.sv - shared constants and types for the switch MCU execution units
//
// Purpose: funct3 operation codes, the I-type ALU sequencing states and the
// default datapath width, shared by the ALU units of the switch MCU core.
package switch_mcu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_CAPT = 3'd2,
    ST_EXEC = 3'd3,
    ST_WAIT = 3'd4,
    ST_WB   = 3'd5
  } alu_state_e;

endpackage

// File: rtl/switch_mcu_alu_itype_if.sv
// rtl/switch_mcu_alu_itype_if.sv - core-side bus of the I-type ALU
//
// Purpose: bundles the decoder/sequencer inputs and the register-file
// read/write ports of the I-type ALU.
// Modports:
//   master - core side: drives in_* (counter, enable, instruction fields,
//            read data), observes out_* (read/write requests, done, illegal)
//   slave  - ALU side: the mirror image
interface switch_mcu_alu_itype_if #(
  parameter int XLEN    = switch_mcu_pkg::XLEN_DEFAULT,
  parameter int RADDR_W = 5,
  parameter int IMM_W   = 12,
  parameter int CNT_W   = 4
) ();

  logic [CNT_W-1:0]   in_cycle_cnt;
  logic               in_en;
  logic [2:0]         in_funct3;
  logic [IMM_W-1:0]   in_imm_type_i;
  logic [RADDR_W-1:0] in_rs1;
  logic [RADDR_W-1:0] in_rd;
  logic [XLEN-1:0]    in_rdata_1;
  logic [RADDR_W-1:0] out_raddr_1;
  logic               out_ren_1;
  logic [RADDR_W-1:0] out_waddr;
  logic               out_wen;
  logic [XLEN-1:0]    out_wdata;
  logic               out_done;
  logic               out_illegal;

  modport master (
    output in_cycle_cnt, in_en, in_funct3, in_imm_type_i, in_rs1, in_rd, in_rdata_1,
    input  out_raddr_1, out_ren_1, out_waddr, out_wen, out_wdata, out_done, out_illegal
  );

  modport slave (
    input  in_cycle_cnt, in_en, in_funct3, in_imm_type_i, in_rs1, in_rd, in_rdata_1,
    output out_raddr_1, out_ren_1, out_waddr, out_wen, out_wdata, out_done, out_illegal
  );

endinterface

// File: rtl/switch_mcu_alu_itype_exec.sv
// rtl/switch_mcu_alu_itype_exec.sv - combinational OP-IMM function unit
//
// Purpose: computes {result, illegal} = f(op, imm, funct3) for every OP-IMM
// operation. Purely combinational so an R-type unit can reuse it by feeding
// a register value in place of the immediate.
// Ports:
//   op      in  XLEN   first operand
//   imm     in  IMM_W  raw I-type immediate (shamt and funct7 bits included)
//   funct3  in  3      operation select
//   result  out XLEN   operation result
//   illegal out 1      shift encoding with reserved immediate bits set
module switch_mcu_alu_itype_exec
  import switch_mcu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int IMM_W = 12
) (
  input  logic [XLEN-1:0]  op,
  input  logic [IMM_W-1:0] imm,
  input  logic [2:0]       funct3,
  output logic [XLEN-1:0]  result,
  output logic             illegal
);

  localparam int SH_W = $clog2(XLEN);
  localparam logic [IMM_W-1:0] SHAMT_MASK = IMM_W'((1 << SH_W) - 1);
  // imm[10] is the funct7 bit that turns a right shift into SRAI.
  localparam logic [IMM_W-1:0] SRA_BIT    = IMM_W'(1 << 10);

  logic [XLEN-1:0]  imm_sext;
  logic [SH_W-1:0]  shamt;
  logic [IMM_W-1:0] hi_bits;
  logic [XLEN-1:0]  sra_res;

  assign imm_sext = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  assign shamt    = imm[SH_W-1:0];
  assign hi_bits  = imm & ~SHAMT_MASK;
  // Kept in its own assignment so the unsigned logical-shift branch cannot
  // turn the arithmetic shift into a logical one through context typing.
  assign sra_res  = $unsigned($signed(op) >>> shamt);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (funct3)
      F3_ADD:  result = op + imm_sext;
      F3_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op) < $signed(imm_sext))};
      F3_SLTU: result = {{(XLEN-1){1'b0}}, (op < imm_sext)};
      F3_XOR:  result = op ^ imm_sext;
      F3_OR:   result = op | imm_sext;
      F3_AND:  result = op & imm_sext;
      F3_SLL: begin
        result  = op << shamt;
        illegal = |hi_bits;
      end
      F3_SR: begin
        if (imm[10]) begin
          result = sra_res;
        end else begin
          result = op >> shamt;
        end
        illegal = |(hi_bits & ~SRA_BIT);
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/switch_mcu_alu_itype.sv
// rtl/switch_mcu_alu_itype.sv - multi-cycle OP-IMM ALU sequenced by the core cycle counter
//
// Purpose: reads rs1 from the register file, registers the operand, executes
// the OP-IMM operation, registers the result and writes it back to rd on the
// write-back slot. Writes to x0 are suppressed; illegal shift encodings are
// flagged instead of written. All outputs are registered single-cycle pulses.
// Ports:
//   in_clk  in  clock
//   in_rst  in  asynchronous active-low reset
//   bus     slave side of switch_mcu_alu_itype_if:
//           in_cycle_cnt, in_en, in_funct3, in_imm_type_i, in_rs1, in_rd,
//           in_rdata_1 / out_raddr_1, out_ren_1, out_waddr, out_wen,
//           out_wdata, out_done, out_illegal
// XLEN must be 32 or 64; WB_CYCLE must be at least RD_CYCLE+3.
module switch_mcu_alu_itype
  import switch_mcu_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int RADDR_W  = 5,
  parameter int IMM_W    = 12,
  parameter int CNT_W    = 4,
  parameter int RD_CYCLE = 1,
  parameter int WB_CYCLE = 4
) (
  input logic              in_clk,
  input logic              in_rst,
  switch_mcu_alu_itype_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_RD   = CNT_W'(RD_CYCLE);
  localparam logic [CNT_W-1:0] CNT_CAPT = CNT_W'(RD_CYCLE + 1);
  localparam logic [CNT_W-1:0] CNT_EXEC = CNT_W'(RD_CYCLE + 2);
  localparam logic [CNT_W-1:0] CNT_WB   = CNT_W'(WB_CYCLE);

  alu_state_e      state;
  logic [XLEN-1:0] op_q;
  logic [XLEN-1:0] res_q;
  logic            ill_q;
  logic [XLEN-1:0] exec_res;
  logic            exec_ill;
  logic            in_pipe;

  switch_mcu_alu_itype_exec #(
    .XLEN  (XLEN),
    .IMM_W (IMM_W)
  ) u_exec (
    .op      (op_q),
    .imm     (bus.in_imm_type_i),
    .funct3  (bus.in_funct3),
    .result  (exec_res),
    .illegal (exec_ill)
  );

  // A result is pending only once EXEC has run; this is what keeps a
  // sequence that skipped the read slot from ever reaching write-back.
  assign in_pipe = (state == ST_EXEC) || (state == ST_WAIT);

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state           <= ST_IDLE;
      op_q            <= '0;
      res_q           <= '0;
      ill_q           <= 1'b0;
      bus.out_raddr_1 <= '0;
      bus.out_ren_1   <= 1'b0;
      bus.out_waddr   <= '0;
      bus.out_wen     <= 1'b0;
      bus.out_wdata   <= '0;
      bus.out_done    <= 1'b0;
      bus.out_illegal <= 1'b0;
    end else begin
      bus.out_raddr_1 <= '0;
      bus.out_ren_1   <= 1'b0;
      bus.out_waddr   <= '0;
      bus.out_wen     <= 1'b0;
      bus.out_wdata   <= '0;
      bus.out_done    <= 1'b0;
      bus.out_illegal <= 1'b0;

      if (!bus.in_en) begin
        state <= ST_IDLE;
      end else if (bus.in_cycle_cnt == CNT_RD) begin
        // The read slot always (re)starts a sequence.
        state           <= ST_READ;
        bus.out_raddr_1 <= bus.in_rs1;
        bus.out_ren_1   <= 1'b1;
      end else if (bus.in_cycle_cnt == CNT_CAPT && state == ST_READ) begin
        state <= ST_CAPT;
        op_q  <= bus.in_rdata_1;
      end else if (bus.in_cycle_cnt == CNT_EXEC && state == ST_CAPT) begin
        state <= ST_EXEC;
        res_q <= exec_res;
        ill_q <= exec_ill;
      end else if (bus.in_cycle_cnt == CNT_WB && in_pipe) begin
        state        <= ST_WB;
        bus.out_done <= 1'b1;
        if (ill_q) begin
          bus.out_illegal <= 1'b1;
        end else if (bus.in_rd != '0) begin
          bus.out_waddr <= bus.in_rd;
          bus.out_wen   <= 1'b1;
          bus.out_wdata <= res_q;
        end
      end else if (in_pipe && bus.in_cycle_cnt > CNT_EXEC && bus.in_cycle_cnt < CNT_WB) begin
        state <= ST_WAIT;
      end else begin
        // Off-schedule counter value: abandon the sequence, keep op_q/res_q.
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_switch_mcu_alu_itype.sv
// tb/tb_switch_mcu_alu_itype.sv - directed self-checking bench for the I-type ALU (XLEN 32 and 64)
module tb_switch_mcu_alu_itype;
  import switch_mcu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  switch_mcu_alu_itype_if #(.XLEN(32), .RADDR_W(5), .IMM_W(12), .CNT_W(4)) bus32 ();
  switch_mcu_alu_itype_if #(.XLEN(64), .RADDR_W(5), .IMM_W(12), .CNT_W(4)) bus64 ();

  switch_mcu_alu_itype #(
    .XLEN(32), .RADDR_W(5), .IMM_W(12), .CNT_W(4), .RD_CYCLE(1), .WB_CYCLE(4)
  ) dut32 (.in_clk(clk), .in_rst(rst), .bus(bus32));

  switch_mcu_alu_itype #(
    .XLEN(64), .RADDR_W(5), .IMM_W(12), .CNT_W(4), .RD_CYCLE(1), .WB_CYCLE(6)
  ) dut64 (.in_clk(clk), .in_rst(rst), .bus(bus64));

  logic [31:0] regs32 [32];
  logic [63:0] regs64 [32];
  assign bus32.in_rdata_1 = regs32[bus32.out_raddr_1];
  assign bus64.in_rdata_1 = regs64[bus64.out_raddr_1];

  int vectors = 0;
  int miscompares = 0;
  bit check_on = 1'b0;

  logic [2:0]  f3;
  logic [11:0] imm;
  logic [4:0]  rs1, rd;

  logic        e_ren [2];
  logic [4:0]  e_raddr [2];
  logic        e_wen [2];
  logic [4:0]  e_waddr [2];
  logic [63:0] e_wdata [2];
  logic        e_done [2];
  logic        e_ill [2];
  bit          ok [2];
  int          last_c [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref32(input logic [2:0] fn, input logic [11:0] im, input logic [31:0] a);
    logic [31:0] s;
    int sh;
    s  = {{20{im[11]}}, im};
    sh = int'(im[4:0]);
    case (fn)
      F3_ADD:  return a + s;
      F3_SLT:  return ($signed(a) < $signed(s)) ? 32'd1 : 32'd0;
      F3_SLTU: return (a < s) ? 32'd1 : 32'd0;
      F3_XOR:  return a ^ s;
      F3_OR:   return a | s;
      F3_AND:  return a & s;
      F3_SLL:  return a << sh;
      default: return (im[10] && a[31]) ? ~((~a) >> sh) : (a >> sh);
    endcase
  endfunction

  function automatic logic [63:0] ref64(input logic [2:0] fn, input logic [11:0] im, input logic [63:0] a);
    logic [63:0] s;
    int sh;
    s  = {{52{im[11]}}, im};
    sh = int'(im[5:0]);
    case (fn)
      F3_ADD:  return a + s;
      F3_SLT:  return ($signed(a) < $signed(s)) ? 64'd1 : 64'd0;
      F3_SLTU: return (a < s) ? 64'd1 : 64'd0;
      F3_XOR:  return a ^ s;
      F3_OR:   return a | s;
      F3_AND:  return a & s;
      F3_SLL:  return a << sh;
      default: return (im[10] && a[63]) ? ~((~a) >> sh) : (a >> sh);
    endcase
  endfunction

  // Bits above shamt must be zero, except bit 10 on a right shift.
  function automatic bit ref_ill(input int xl, input logic [2:0] fn, input logic [11:0] im);
    int sh;
    logic [11:0] hi;
    sh = (xl == 32) ? 5 : 6;
    hi = im >> sh;
    if (fn == F3_SLL) return hi != 12'd0;
    if (fn == F3_SR) return (hi & ~(12'd1 << (10 - sh))) != 12'd0;
    return 1'b0;
  endfunction

  task automatic model_clear(input int d);
    e_ren[d] = 1'b0; e_raddr[d] = '0; e_wen[d] = 1'b0; e_waddr[d] = '0;
    e_wdata[d] = '0; e_done[d] = 1'b0; e_ill[d] = 1'b0;
  endtask

  // Expected outputs after the next edge: a write-back happens only when the
  // counter ran 1,2,..,WB consecutively with the unit enabled throughout.
  task automatic model_step(input int d, input int c, input logic en);
    int wb;
    logic [63:0] r;
    bit il;
    wb = (d == 0) ? 4 : 6;
    model_clear(d);
    if (!en) begin
      ok[d] = 1'b0;
    end else if (c == 1) begin
      ok[d] = 1'b1;
      e_ren[d] = 1'b1;
      e_raddr[d] = rs1;
    end else if (ok[d] && c == last_c[d] + 1 && c < wb) begin
      ok[d] = 1'b1;
    end else if (ok[d] && c == last_c[d] + 1 && c == wb) begin
      il = ref_ill((d == 0) ? 32 : 64, f3, imm);
      r  = (d == 0) ? {32'd0, ref32(f3, imm, regs32[rs1])} : ref64(f3, imm, regs64[rs1]);
      e_done[d] = 1'b1;
      if (il) begin
        e_ill[d] = 1'b1;
      end else if (rd != 5'd0) begin
        e_wen[d] = 1'b1;
        e_waddr[d] = rd;
        e_wdata[d] = r;
      end
      ok[d] = 1'b0;
    end else begin
      ok[d] = 1'b0;
    end
    last_c[d] = c;
  endtask

  task automatic step(input int which, input int c, input logic en);
    @(negedge clk);
    bus32.in_cycle_cnt = 4'(c);        bus64.in_cycle_cnt = 4'(c);
    bus32.in_en = en && (which == 0);  bus64.in_en = en && (which == 1);
    bus32.in_funct3 = f3;              bus64.in_funct3 = f3;
    bus32.in_imm_type_i = imm;         bus64.in_imm_type_i = imm;
    bus32.in_rs1 = rs1;                bus64.in_rs1 = rs1;
    bus32.in_rd = rd;                  bus64.in_rd = rd;
    model_step(0, c, bus32.in_en);
    model_step(1, c, bus64.in_en);
  endtask

  task automatic run(input int which, input logic [2:0] f3_i, input logic [11:0] imm_i,
                     input logic [4:0] rs1_i, input logic [4:0] rd_i, input int drop_at,
                     input int bad_at, input logic l_wen, input logic [63:0] l_wdata,
                     input logic l_done, input logic l_ill);
    int wb;
    f3 = f3_i; imm = imm_i; rs1 = rs1_i; rd = rd_i;
    wb = (which == 0) ? 4 : 6;
    for (int c = 0; c <= wb + 1; c++) begin
      step(which, (c == bad_at) ? 9 : c, c != drop_at);
      if (c == 1) begin
        @(posedge clk); #2;
        check("lit_ren", 64'(which ? bus64.out_ren_1 : bus32.out_ren_1), 64'd1);
        check("lit_raddr", 64'(which ? bus64.out_raddr_1 : bus32.out_raddr_1), 64'(rs1_i));
      end
      if (c == wb) begin
        @(posedge clk); #2;
        check("lit_wen", 64'(which ? bus64.out_wen : bus32.out_wen), 64'(l_wen));
        check("lit_wdata", which ? bus64.out_wdata : 64'(bus32.out_wdata), l_wdata);
        check("lit_done", 64'(which ? bus64.out_done : bus32.out_done), 64'(l_done));
        check("lit_illegal", 64'(which ? bus64.out_illegal : bus32.out_illegal), 64'(l_ill));
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (check_on) begin
      check("d32_ren", 64'(bus32.out_ren_1), 64'(e_ren[0]));
      check("d32_raddr", 64'(bus32.out_raddr_1), 64'(e_raddr[0]));
      check("d32_wen", 64'(bus32.out_wen), 64'(e_wen[0]));
      check("d32_waddr", 64'(bus32.out_waddr), 64'(e_waddr[0]));
      check("d32_wdata", 64'(bus32.out_wdata), e_wdata[0]);
      check("d32_done", 64'(bus32.out_done), 64'(e_done[0]));
      check("d32_illegal", 64'(bus32.out_illegal), 64'(e_ill[0]));
      check("d64_ren", 64'(bus64.out_ren_1), 64'(e_ren[1]));
      check("d64_raddr", 64'(bus64.out_raddr_1), 64'(e_raddr[1]));
      check("d64_wen", 64'(bus64.out_wen), 64'(e_wen[1]));
      check("d64_waddr", 64'(bus64.out_waddr), 64'(e_waddr[1]));
      check("d64_wdata", bus64.out_wdata, e_wdata[1]);
      check("d64_done", 64'(bus64.out_done), 64'(e_done[1]));
      check("d64_illegal", 64'(bus64.out_illegal), 64'(e_ill[1]));
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      regs32[i] = 32'h1234_5600 + 32'(i);
      regs64[i] = 64'h0123_4567_89AB_CD00 + 64'(i);
    end
    regs32[0] = '0;  regs64[0] = '0;
    regs32[1] = 32'h7FFF_FFFF;
    regs32[2] = 32'h8000_0000;
    regs32[5] = 32'h0000_0010;
    regs64[2] = 64'h8000_0000_0000_0000;
    regs64[5] = 64'h0000_0001_0000_0000;
    regs64[6] = 64'h0000_0000_0000_0001;
    f3 = F3_ADD; imm = '0; rs1 = '0; rd = '0;
    bus32.in_cycle_cnt = '0; bus32.in_en = 1'b0; bus32.in_funct3 = '0;
    bus32.in_imm_type_i = '0; bus32.in_rs1 = '0; bus32.in_rd = '0;
    bus64.in_cycle_cnt = '0; bus64.in_en = 1'b0; bus64.in_funct3 = '0;
    bus64.in_imm_type_i = '0; bus64.in_rs1 = '0; bus64.in_rd = '0;
    for (int d = 0; d < 2; d++) begin
      model_clear(d);
      ok[d] = 1'b0;
      last_c[d] = 0;
    end

    repeat (3) @(negedge clk);
    check("rst_ren", 64'(bus32.out_ren_1), 64'd0);
    check("rst_raddr", 64'(bus32.out_raddr_1), 64'd0);
    check("rst_wen", 64'(bus32.out_wen), 64'd0);
    check("rst_wdata", 64'(bus32.out_wdata), 64'd0);
    check("rst_done", 64'(bus32.out_done), 64'd0);
    check("rst_illegal", 64'(bus32.out_illegal), 64'd0);
    check("rst64_wen", 64'(bus64.out_wen), 64'd0);
    check("rst64_done", 64'(bus64.out_done), 64'd0);
    rst = 1'b1;
    check_on = 1'b1;

    // Pin the model on hand-computed values.
    check("pin_addi", 64'(ref32(F3_ADD, 12'hFFF, 32'h10)), 64'h0000_000F);
    check("pin_sltiu", 64'(ref32(F3_SLTU, 12'hFFF, 32'h7FFF_FFFF)), 64'd1);
    check("pin_srai64", ref64(F3_SR, 12'h43F, 64'h8000_0000_0000_0000), 64'hFFFF_FFFF_FFFF_FFFF);
    check("pin_ill_slli", 64'(ref_ill(32, F3_SLL, 12'h421)), 64'd1);

    //  dut op       imm      rs1 rd  drop bad  wen   wdata                      done  ill
    run(0, F3_ADD,  12'hFFF, 5,  6,  -1,  -1,  1'b1, 64'h0000_000F,             1'b1, 1'b0);
    run(0, F3_SLTU, 12'hFFF, 1,  7,  -1,  -1,  1'b1, 64'h0000_0001,             1'b1, 1'b0);
    run(0, F3_SLT,  12'hFFF, 1,  7,  -1,  -1,  1'b1, 64'h0000_0000,             1'b1, 1'b0);
    run(0, F3_SR,   12'h41F, 2,  9,  -1,  -1,  1'b1, 64'hFFFF_FFFF,             1'b1, 1'b0);
    run(0, F3_SR,   12'h01F, 2,  9,  -1,  -1,  1'b1, 64'h0000_0001,             1'b1, 1'b0);
    run(0, F3_XOR,  12'h8F0, 5,  10, -1,  -1,  1'b1, 64'hFFFF_F8E0,             1'b1, 1'b0);
    run(0, F3_OR,   12'h8F0, 5,  11, -1,  -1,  1'b1, 64'hFFFF_F8F0,             1'b1, 1'b0);
    run(0, F3_AND,  12'h8F0, 5,  12, -1,  -1,  1'b1, 64'h0000_0010,             1'b1, 1'b0);
    run(0, F3_SLL,  12'h004, 5,  13, -1,  -1,  1'b1, 64'h0000_0100,             1'b1, 1'b0);
    run(0, F3_SLL,  12'h421, 2,  8,  -1,  -1,  1'b0, 64'h0,                     1'b1, 1'b1);
    run(0, F3_SR,   12'h81F, 2,  8,  -1,  -1,  1'b0, 64'h0,                     1'b1, 1'b1);
    run(0, F3_ADD,  12'h005, 5,  0,  -1,  -1,  1'b0, 64'h0,                     1'b1, 1'b0);
    run(0, F3_ADD,  12'h001, 5,  6,  3,   -1,  1'b0, 64'h0,                     1'b0, 1'b0);
    run(0, F3_ADD,  12'h001, 5,  6,  -1,  2,   1'b0, 64'h0,                     1'b0, 1'b0);
    run(1, F3_SR,   12'h43F, 2,  3,  -1,  -1,  1'b1, 64'hFFFF_FFFF_FFFF_FFFF,   1'b1, 1'b0);
    run(1, F3_ADD,  12'hFFF, 5,  4,  -1,  -1,  1'b1, 64'h0000_0000_FFFF_FFFF,   1'b1, 1'b0);
    run(1, F3_SLL,  12'h020, 6,  4,  -1,  -1,  1'b1, 64'h0000_0001_0000_0000,   1'b1, 1'b0);
    run(1, F3_SLL,  12'h420, 6,  4,  -1,  -1,  1'b0, 64'h0,                     1'b1, 1'b1);

    // Asynchronous reset in the middle of a sequence.
    f3 = F3_ADD; imm = 12'h001; rs1 = 5'd5; rd = 5'd6;
    step(0, 0, 1'b1);
    step(0, 1, 1'b1);
    @(posedge clk); #2;
    check("rst_mid_ren_before", 64'(bus32.out_ren_1), 64'd1);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_ren", 64'(bus32.out_ren_1), 64'd0);
    check("rst_mid_raddr", 64'(bus32.out_raddr_1), 64'd0);
    model_clear(0); model_clear(1);
    ok[0] = 1'b0; ok[1] = 1'b0;
    step(0, 2, 1'b1);
    rst = 1'b1;
    step(0, 3, 1'b1);
    step(0, 4, 1'b1);
    @(posedge clk); #2;
    check("rst_mid_no_done", 64'(bus32.out_done), 64'd0);
    check("rst_mid_no_wen", 64'(bus32.out_wen), 64'd0);
    step(0, 5, 1'b1);
    step(0, 0, 1'b0);
    step(0, 0, 1'b0);
    @(posedge clk); #3;
    check_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/switch_mcu_alu_itype.md
Name: switch_mcu_alu_itype

Overview:
- Parametrised multi-cycle I-type ALU for the switch MCU core. Executes all OP-IMM operations (ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI) in one unit, selected by funct3/funct7.
- Sequenced by the core's shared cycle counter. Issues one register-file read, registers the operand and the result, then issues one write-back.
- Adds operand/result registering, illegal-encoding detection, an x0 write guard and a done pulse.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- RADDR_W, 5, register address width.
- IMM_W, 12, I-type immediate width.
- CNT_W, 4, cycle counter width.
- RD_CYCLE, 1, counter value on which the read is issued.
- WB_CYCLE, 4, counter value on which the write-back is issued; must be >= RD_CYCLE+3.

Ports:
- in_clk  in  1  clock
- in_rst  in  1  asynchronous active-low reset
- in_cycle_cnt  in  CNT_W  core instruction cycle counter
- in_en  in  1  decoder selects this unit for the current instruction
- in_funct3  in  3  operation select
- in_imm_type_i  in  IMM_W  raw I-type immediate (includes funct7/shamt bits)
- in_rs1  in  RADDR_W  source register
- in_rd  in  RADDR_W  destination register
- in_rdata_1  in  XLEN  register-file read data, valid the cycle after out_ren_1
- out_raddr_1  out  RADDR_W  read address
- out_ren_1  out  1  read enable
- out_waddr  out  RADDR_W  write address
- out_wen  out  1  write enable
- out_wdata  out  XLEN  write data
- out_done  out  1  one-cycle pulse at write-back
- out_illegal  out  1  one-cycle pulse at write-back slot for an illegal shift encoding

Behaviour:
- Reset: in_rst is asynchronous, active-low; clock is in_clk. All outputs and the internal registers (op_q, res_q, ill_q, state) reset to 0.
- All outputs are registered. Every output defaults to 0 in any cycle not listed below (single-cycle pulses).
- State is derived from in_cycle_cnt while in_en=1: IDLE → READ (cnt==RD_CYCLE) → CAPT (cnt==RD_CYCLE+1) → EXEC (cnt==RD_CYCLE+2) → WAIT (until WB_CYCLE) → WB (cnt==WB_CYCLE) → IDLE.
- READ: out_raddr_1<=in_rs1, out_ren_1<=1.
- CAPT: op_q<=in_rdata_1.
- EXEC: res_q<=f(op_q, imm_sext), where imm_sext is the sign-extension of the immediate to XLEN. Also ill_q<=illegal-encoding check. Operations:
  - ADDI: modulo 2^XLEN add, no overflow flag.
  - SLTI: signed compare, result 1/0 zero-extended.
  - SLTIU: unsigned compare against the sign-extended immediate. Imm 0xFFF compares as all-ones.
  - XORI / ORI / ANDI: bitwise against imm_sext.
  - Shifts: shamt = imm[log2(XLEN)-1:0].
    - funct3=001: SLLI.
    - funct3=101 with imm[10]=0: SRLI.
    - funct3=101 with imm[10]=1: SRAI.
- Illegal encoding: funct3 ∈ {001,101} and any imm bit above shamt is set other than imm[10] (SRAI). imm[10]=1 with funct3=001 is also illegal.
- WB:
  - Legal and in_rd≠0: out_waddr<=in_rd, out_wen<=1, out_wdata<=res_q, out_done<=1.
  - in_rd==0: wen=0, waddr=0, wdata=0, done=1.
  - Illegal: wen=0, out_illegal<=1, done=1.
- in_en=0 in any cycle: all outputs 0 next edge; state returns to IDLE; op_q/res_q hold but are never written back. Re-asserting in_en mid-sequence without cnt passing RD_CYCLE gives no write-back.
- in_cycle_cnt values outside the schedule: outputs 0, registers hold.
- No back-pressure: the register file accepts every read and write in the cycle issued.

Decomposition:
- Shared package switch_mcu_pkg: funct3 constants (F3_ADD, F3_SLT, F3_SLTU, F3_XOR, F3_OR, F3_AND, F3_SLL, F3_SR), state encoding, XLEN default.
- One sub-module: switch_mcu_alu_itype_exec, combinational f(op, imm, funct3) → {result, illegal}. It is reusable by a future R-type unit.

Test Plan:
- ADDI x5=0x0000_0010, imm=0xFFF, rd=6 → cnt1 ren=1 raddr=5; cnt4 wen=1 waddr=6 wdata=0x0000_000F, done=1.
- SLTIU x1=0x7FFF_FFFF, imm=0xFFF → wdata=1. SLTI same operands → wdata=0.
- SRAI x2=0x8000_0000, imm=0x41F → wdata=0xFFFF_FFFF. SRLI imm=0x01F → wdata=0x0000_0001.
- SLLI with imm=0x421 (illegal) → wen=0, out_illegal=1 at cnt4, done=1. ADDI with rd=0 → wen=0, done=1.
- in_en dropped at cnt3 → no wen/done at cnt4. Async reset asserted at cnt2 → all outputs 0 immediately.
- XLEN=64, WB_CYCLE=6: SRAI imm=0x43F on 0x8000_0000_0000_0000 → 64'hFFFF_FFFF_FFFF_FFFF at cnt6.
